// File: rtl/fp_cmd_decoder_pkg.sv
// Shared definitions for the front-panel SPI command decoder:
// FSM state encoding, default opcode and register-bank addresses.
`timescale 1ns/1ps
package fp_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [5:0] OPCODE_DEF = 6'b101000;

  localparam logic [1:0] ADDR_A = 2'd0;
  localparam logic [1:0] ADDR_B = 2'd1;
  localparam logic [1:0] ADDR_C = 2'd2;
  localparam logic [1:0] ADDR_D = 2'd3;

endpackage

// File: rtl/fp_cmd_decoder_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with rising/falling
// edge detection on the synchronised value.
`timescale 1ns/1ps
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/fp_cmd_decoder.sv
// SPI-slave command decoder: 16-bit frames {opcode,addr},{data} write one of
// four front-panel registers; malformed or aborted frames pulse FRAME_ERR.
`timescale 1ns/1ps
module fp_cmd_decoder
  import fp_cmd_decoder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] OPCODE      = OPCODE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CSN,
  output logic [7:0] REG_A,
  output logic [7:0] REG_B,
  output logic [7:0] REG_C,
  output logic [7:0] REG_D,
  output logic       WR_STROBE,
  output logic [1:0] WR_ADDR,
  output logic       FRAME_ERR
);

  localparam int             FW        = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0]  FLUSH_MAX = FW'(SYNC_STAGES);

  logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk (CLK),
    .rst (RST),
    .din (SCLK),
    .dout(sclk_lvl_unused),
    .rise(sclk_rise),
    .fall(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk (CLK),
    .rst (RST),
    .din (CSN),
    .dout(csn_s),
    .rise(csn_rise),
    .fall(csn_fall)
  );

  // MOSI gets the same depth as SCLK so the sampled bit lines up with the edge
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       addr_q, addr_d;
  logic [3:0][7:0]  regs_q, regs_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [1:0]       wr_addr_q, wr_addr_d;
  logic             frame_err_q, frame_err_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic             armed_q, armed_d;
  logic [7:0]       shifted;
  logic             last_edge;

  // After reset, a CSN already held low must not look like a new frame start:
  // only arm once the flushed synchroniser has shown CSN high.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    flush_d     = (flush_q == FLUSH_MAX) ? flush_q : flush_q + 1'b1;
    armed_d     = armed_q | ((flush_q == FLUSH_MAX) & csn_s);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    shifted     = {shreg_q[6:0], mosi_s};
    last_edge   = sclk_rise && (cnt_q == 4'd7);

    unique case (state_q)
      ST_IDLE: begin
        if (csn_fall && armed_q) begin
          state_d = ST_CMD;
          cnt_d   = 4'd0;
          shreg_d = 8'h00;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 4'd1;
          if (last_edge) begin
            cnt_d   = 4'd0;
            shreg_d = 8'h00;
            if (shifted[7:2] == OPCODE) begin
              addr_d  = shifted[1:0];
              state_d = ST_DATA;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        if (csn_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (sclk_rise) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 4'd1;
          if (last_edge) begin
            regs_d[addr_q] = shifted;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
            state_d        = ST_HOLD;
          end
        end
        // A CSN rise coincident with the final edge still completes the write
        if (csn_rise) begin
          state_d = ST_IDLE;
          if (!last_edge) frame_err_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (csn_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mosi_sync_q <= '0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= 8'h00;
      addr_q      <= 2'b00;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign REG_A     = regs_q[ADDR_A];
  assign REG_B     = regs_q[ADDR_B];
  assign REG_C     = regs_q[ADDR_C];
  assign REG_D     = regs_q[ADDR_D];
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign FRAME_ERR = frame_err_q;

endmodule
